clk_div_multi: RTL and testbench
================================

# clk_div_multi

Parametrised multi-channel clock-enable / divided-clock generator; successor to the fixed-ratio `clk_div`. Each of `CH` channels divides `clk` by a runtime-programmable integer N ≥ 2. Each channel produces a near-50 % divided level and a one-cycle tick for use as a clock enable. Sits between the system clock and slow consumers (FND scan, UART baud, debouncers); all outputs are synchronous to `clk`.

## Interface
- `CH`, default 2: number of independent channels (1–8).
- `DIV_W`, default 16: divisor width in bits.
- `DIV_DEFAULT`, default 10: divisor loaded into every channel at reset; must be ≥ 2 and < 2^DIV_W.
- Port widths below use `SEL_W` = max(1, $clog2(CH)).

Ports:
- `clk`, input, 1: system clock; all logic is on the rising edge.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `en`, input, CH: per-channel run enable.
- `div_wr`, input, 1: divisor write strobe; single cycle.
- `div_sel`, input, SEL_W: target channel of the write.
- `div_val`, input, DIV_W: new divisor N.
- `clk_out`, output, CH: registered divided level per channel.
- `tick`, output, CH: registered one-cycle pulse, once per period.
- `div_err`, output, 1: one-cycle pulse when a write is rejected.
- `sync`, input, 1: present only with `CLK_DIV_SYNC_EN`.

## Operation
- Per channel state:
  - `cnt`, DIV_W bits, counts 0..N-1.
  - `div`, the active N.
  - `pend_div` plus a `pend_v` flag.
- Enabled channel:
  - `cnt` increments each cycle.
  - At `cnt == N-1`, `cnt` wraps to 0.
- `tick[i]` = 1 exactly in the cycle where `cnt == N-1`.
- `clk_out[i]` = 1 iff `cnt >= (N>>1)`:
  - low for floor(N/2) cycles after each wrap, then high for ceil(N/2) cycles.
  - N=10 gives 5 low / 5 high; N=3 gives 1 low / 2 high.
  - `tick` coincides with the last high cycle.
- Disabled channel (`en[i]`=0):
  - `cnt` held at 0; `clk_out[i]`=0; `tick[i]`=0.
  - When `en` returns to 1, the channel starts a fresh period from `cnt`=0.
- Divisor write, accepted when `div_wr`=1, `div_sel` < CH and `div_val` ≥ 2:
  - The value goes to the target's `pend_div` and `pend_v` is set.
  - A later write before application overwrites it; the last write wins.
- Pending application, glitch-free:
  - On an enabled channel, `div` ← `pend_div` on the cycle `cnt` wraps to 0.
  - On a disabled channel, it is applied on the next clock.
  - `pend_v` clears when the value is applied.
- Rejected write (`div_val` < 2 or `div_sel` ≥ CH):
  - No state changes.
  - `div_err` pulses for one cycle, the cycle after the strobe.
- Width rule: comparisons are unsigned at DIV_W bits. N = 2^DIV_W-1 is legal.

## Timing
- Reset values: `cnt`=0, `div`=DIV_DEFAULT, `pend_v`=0, `clk_out`=0, `tick`=0, `div_err`=0.
- Reset asserted mid-period forces these values immediately; there is no completion of the current period.
- First `tick` after reset release with `en` high: in the Nth cycle; `cnt` reaches N-1 on clock N-1 after release.
- All outputs are registered from counter state; there is no combinational path from inputs to outputs.
- A write that lands in the same cycle as the target's wrap is not applied at that wrap. It is applied at the following wrap, so the old N completes exactly one more period.
- `en` falling in the same cycle as a wrap: the channel goes idle and `tick` for that cycle is still emitted.

## Configuration
- `CLK_DIV_SYNC_EN` defined:
  - adds the `sync` input.
  - `sync`=1 forces `cnt`=0 on every enabled channel at the next clock, phase-aligning all channels.
  - Pending divisors are applied at that forced wrap.
  - `tick` is not emitted for a truncated period.
  - `sync` has priority over a normal wrap in the same cycle.
- Not defined: the port is absent and channels are free-running.

## Test plan
- Reset, CH=2, DIV_DEFAULT=10, 10 ns clock, release reset at 20 ns, `en`=2'b11 → `clk_out` period 100 ns (5 low / 5 high); `tick` high 10 ns every 100 ns; all outputs 0 during reset.
- Write `div_sel`=1, `div_val`=3 while ch1 `cnt`=4 → ch1 finishes the 10-cycle period, then runs 1 low / 2 high with `tick` every 3 cycles; ch0 is unaffected.
- Write `div_val`=1 or `div_sel`=2 (CH=2) → `div_err` is a single-cycle pulse; `div` and `pend_v` are unchanged.
- Drop `en[0]` for 7 cycles mid-period, then raise it → `clk_out[0]`/`tick[0]` are 0 while low; the first tick comes 10 cycles after re-enable.
- Assert `reset_n`=0 asynchronously (not clock-aligned) mid-period after reprogramming ch1 to 3 → outputs are 0 immediately; after release both channels run at N=10.
- With `CLK_DIV_SYNC_EN`, ch0 N=4, ch1 N=6, pulse `sync` → both `cnt` are 0 next cycle; no tick on the truncated period; `tick[0]` and `tick[1]` coincide every 12 cycles thereafter.

Source files
------------

// File: rtl/clk_div_multi.sv
// clk_div_multi: multi-channel, runtime-programmable clock divider.
// Each channel divides clk by N >= 2 and produces a near-50% divided level
// (clk_out) plus a one-cycle tick in the last high cycle of each period.
// Divisor writes are staged in a pending register and applied only at a
// period boundary, so the divided outputs never glitch.
// Optional feature: define CLK_DIV_SYNC_EN to add the sync input, which
// restarts every enabled channel at cnt = 0 on the next clock.
module clk_div_multi #(
  parameter int  CH          = 2,
  parameter int  DIV_W       = 16,
  parameter int  DIV_DEFAULT = 10,
  localparam int SEL_W       = (CH > 32'sd1) ? $clog2(CH) : 32'sd1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [CH-1:0]    en,
  input  logic             div_wr,
  input  logic [SEL_W-1:0] div_sel,
  input  logic [DIV_W-1:0] div_val,
  output logic [CH-1:0]    clk_out,
  output logic [CH-1:0]    tick,
  output logic             div_err
`ifdef CLK_DIV_SYNC_EN
  ,
  input  logic             sync
`endif
);

  localparam logic [DIV_W-1:0] ONE_C     = DIV_W'(1'b1);
  localparam logic [DIV_W-1:0] TWO_C     = DIV_W'(2'd2);
  localparam logic [DIV_W-1:0] RST_DIV_C = DIV_W'(DIV_DEFAULT);
  localparam logic [SEL_W:0]   CH_C      = (SEL_W + 1)'(CH);

  // Per-channel state
  logic [DIV_W-1:0] cnt_q  [CH];
  logic [DIV_W-1:0] cnt_d  [CH];
  logic [DIV_W-1:0] div_q  [CH];
  logic [DIV_W-1:0] div_d  [CH];
  logic [DIV_W-1:0] pend_q [CH];
  logic [DIV_W-1:0] pend_d [CH];
  logic [CH-1:0]    pend_v_q;
  logic [CH-1:0]    pend_v_d;

  // Registered outputs
  logic [CH-1:0]    clk_out_q;
  logic [CH-1:0]    clk_out_d;
  logic [CH-1:0]    tick_q;
  logic [CH-1:0]    tick_d;
  logic             div_err_q;
  logic             div_err_d;

  // Combinational helpers
  logic             sync_s;
  logic             sel_bad_s;
  logic             val_bad_s;
  logic             wr_ok_s;
  logic [CH-1:0]    wr_hit_s;
  logic [CH-1:0]    wrap_s;
  logic [CH-1:0]    restart_s;
  logic [CH-1:0]    apply_s;

`ifdef CLK_DIV_SYNC_EN
  assign sync_s = sync;
`else
  assign sync_s = 1'b0;
`endif

  // Validate a divisor write and decode which channel it targets.
  always_comb begin
    sel_bad_s = ({1'b0, div_sel} >= CH_C);
    val_bad_s = (div_val < TWO_C);
    wr_ok_s   = div_wr & ~sel_bad_s & ~val_bad_s;
    div_err_d = div_wr & (sel_bad_s | val_bad_s);
    wr_hit_s  = {CH{1'b0}};
    for (int i = 0; i < CH; i++) begin
      wr_hit_s[i] = wr_ok_s && (div_sel == SEL_W'(i));
    end
  end

  // Per-channel counter, divisor staging and next output values.
  always_comb begin
    cnt_d     = cnt_q;
    div_d     = div_q;
    pend_d    = pend_q;
    pend_v_d  = pend_v_q;
    wrap_s    = {CH{1'b0}};
    restart_s = {CH{1'b0}};
    apply_s   = {CH{1'b0}};
    clk_out_d = {CH{1'b0}};
    tick_d    = {CH{1'b0}};
    for (int i = 0; i < CH; i++) begin
      // cnt never exceeds div - 1: a new divisor only lands when cnt is 0.
      wrap_s[i]    = en[i] && (cnt_q[i] == (div_q[i] - ONE_C));
      // sync takes precedence; the result is the same restart either way.
      restart_s[i] = wrap_s[i] || (en[i] && sync_s);
      apply_s[i]   = pend_v_q[i] && (restart_s[i] || !en[i]);

      if (!en[i] || restart_s[i]) begin
        cnt_d[i] = {DIV_W{1'b0}};
      end else begin
        cnt_d[i] = cnt_q[i] + ONE_C;
      end

      if (apply_s[i]) begin
        div_d[i] = pend_q[i];
      end else begin
        div_d[i] = div_q[i];
      end

      // A write arriving in the same cycle as an application re-arms the
      // pending slot, so it takes effect at the following boundary.
      if (wr_hit_s[i]) begin
        pend_d[i]   = div_val;
        pend_v_d[i] = 1'b1;
      end else if (apply_s[i]) begin
        pend_d[i]   = pend_q[i];
        pend_v_d[i] = 1'b0;
      end else begin
        pend_d[i]   = pend_q[i];
        pend_v_d[i] = pend_v_q[i];
      end

      // Outputs are decoded from next state so they line up with cnt.
      // With cnt held at 0 and N >= 2, both decodes are 0 on idle channels.
      clk_out_d[i] = (cnt_d[i] >= (div_d[i] >> 1'b1));
      tick_d[i]    = (cnt_d[i] == (div_d[i] - ONE_C));
    end
  end

  // State and output registers; reset aborts any period in progress.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < CH; i++) begin
        cnt_q[i]  <= {DIV_W{1'b0}};
        div_q[i]  <= RST_DIV_C;
        pend_q[i] <= RST_DIV_C;
      end
      pend_v_q  <= {CH{1'b0}};
      clk_out_q <= {CH{1'b0}};
      tick_q    <= {CH{1'b0}};
      div_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      pend_q    <= pend_d;
      pend_v_q  <= pend_v_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
      div_err_q <= div_err_d;
    end
  end

  assign clk_out = clk_out_q;
  assign tick    = tick_q;
  assign div_err = div_err_q;

endmodule

// File: tb/tb_clk_div_multi.sv
// Self-checking bench for clk_div_multi. A behavioural model predicts the
// outputs for every clock; predictions are queued when stimulus is driven
// and compared against the DUT just after the following rising edge.
// A second instance with CH=3 covers out-of-range channel selects.
// Define CLK_DIV_SYNC_EN to include the sync phase-alignment scenario.
module tb_clk_div_multi;

  localparam int CH    = 2;
  localparam int DIV_W = 16;

  logic              clk      = 1'b0;
  logic              reset_n  = 1'b0;
  logic [CH-1:0]     en       = 2'b00;
  logic              div_wr   = 1'b0;
  logic              div_sel  = 1'b0;
  logic [DIV_W-1:0]  div_val  = 16'd0;
  logic [CH-1:0]     clk_out;
  logic [CH-1:0]     tick;
  logic              div_err;
  logic              sync     = 1'b0;

  logic [2:0]        en3      = 3'b000;
  logic              div_wr3  = 1'b0;
  logic [1:0]        div_sel3 = 2'd0;
  logic [DIV_W-1:0]  div_val3 = 16'd0;
  logic [2:0]        clk_out3;
  logic [2:0]        tick3;
  logic              div_err3;

  int n_vec = 0;
  int n_err = 0;
  int sel_i  = 0;
  int sel3_i = 0;

  // Model state
  int m_cnt  [CH];
  int m_div  [CH];
  int m_pend [CH];
  bit m_pv   [CH];
  bit m_err;
  bit m_err3;

  typedef struct {
    logic [CH-1:0] clk_out;
    logic [CH-1:0] tick;
    logic          err;
    logic          err3;
  } exp_t;

  exp_t sb_q[$];

  clk_div_multi #(.CH(CH), .DIV_W(DIV_W), .DIV_DEFAULT(10)) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (en),
    .div_wr  (div_wr),
    .div_sel (div_sel),
    .div_val (div_val),
    .clk_out (clk_out),
    .tick    (tick),
    .div_err (div_err)
`ifdef CLK_DIV_SYNC_EN
    ,
    .sync    (sync)
`endif
  );

  clk_div_multi #(.CH(3), .DIV_W(DIV_W), .DIV_DEFAULT(10)) u_dut3 (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (en3),
    .div_wr  (div_wr3),
    .div_sel (div_sel3),
    .div_val (div_val3),
    .clk_out (clk_out3),
    .tick    (tick3),
    .div_err (div_err3)
`ifdef CLK_DIV_SYNC_EN
    ,
    .sync    (sync)
`endif
  );

  // 10 ns system clock
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  function automatic void model_reset();
    for (int c = 0; c < CH; c++) begin
      m_cnt[c]  = 0;
      m_div[c]  = 10;
      m_pend[c] = 10;
      m_pv[c]   = 1'b0;
    end
    m_err  = 1'b0;
    m_err3 = 1'b0;
  endfunction

  // Advance the model by one clock using the currently driven inputs.
  function automatic void model_clock();
    bit ok;
    ok     = div_wr && (sel_i < CH) && (int'(div_val) >= 2);
    m_err  = div_wr && !ok;
    m_err3 = div_wr3 && ((sel3_i >= 3) || (int'(div_val3) < 2));
    for (int c = 0; c < CH; c++) begin
      bit take;
      take = 1'b0;
      if (!en[c]) begin
        m_cnt[c] = 0;
        take = m_pv[c];
      end else if (sync || (m_cnt[c] == m_div[c] - 1)) begin
        m_cnt[c] = 0;
        take = m_pv[c];
      end else begin
        m_cnt[c] = m_cnt[c] + 1;
      end
      if (take) begin
        m_div[c] = m_pend[c];
        m_pv[c]  = 1'b0;
      end
      if (ok && (sel_i == c)) begin
        m_pend[c] = int'(div_val);
        m_pv[c]   = 1'b1;
      end
    end
  endfunction

  // One clock: predict, queue, clock the DUT, then compare after the edge.
  task automatic step();
    exp_t e;
    exp_t got;
    div_sel  = sel_i[0];
    div_sel3 = sel3_i[1:0];
    model_clock();
    for (int c = 0; c < CH; c++) begin
      e.clk_out[c] = (m_cnt[c] >= (m_div[c] / 2));
      e.tick[c]    = (m_cnt[c] == (m_div[c] - 1));
    end
    e.err  = m_err;
    e.err3 = m_err3;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    check_eq("clk_out",  32'(clk_out),  32'(got.clk_out));
    check_eq("tick",     32'(tick),     32'(got.tick));
    check_eq("div_err",  32'(div_err),  32'(got.err));
    check_eq("div_err3", 32'(div_err3), 32'(got.err3));
    check_eq("idle3",    32'({tick3, clk_out3}), 32'd0);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic write(input int sel, input logic [DIV_W-1:0] val);
    div_wr  = 1'b1;
    sel_i   = sel;
    div_val = val;
    step();
    div_wr  = 1'b0;
  endtask

  task automatic write3(input int sel, input logic [DIV_W-1:0] val);
    div_wr3  = 1'b1;
    sel3_i   = sel;
    div_val3 = val;
    step();
    div_wr3  = 1'b0;
  endtask

  // Step until the model counter of channel c equals target (bounded).
  task automatic wait_cnt(input int c, input int target, input string tag);
    int k;
    k = 0;
    while ((m_cnt[c] != target) && (k < 100)) begin
      step();
      k++;
    end
    check_eq(tag, 32'(k < 100), 32'd1);
  endtask

  task automatic wait_applied(input string tag);
    int k;
    k = 0;
    while ((m_pv[0] || m_pv[1]) && (k < 100)) begin
      step();
      k++;
    end
    check_eq(tag, 32'(k < 100), 32'd1);
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_clk_out"}, 32'(clk_out), 32'd0);
    check_eq({tag, "_tick"},    32'(tick),    32'd0);
    check_eq({tag, "_div_err"}, 32'(div_err), 32'd0);
  endtask

  initial begin
    model_reset();
    en = 2'b11;
    #2;
    check_zero("rst_a");
    @(negedge clk);
    check_zero("rst_b");
    @(negedge clk);
    reset_n = 1'b1;

    // Default N=10 on both channels: 5 low / 5 high, tick every 10
    idle(25);

    // Reprogram ch1 to 3 while its cnt is 4
    wait_cnt(1, 4, "wait_c1_4");
    write(1, 16'd3);
    idle(20);

    // Write landing on ch0's wrap: old N runs one more full period
    wait_cnt(0, 9, "wait_c0_wrap");
    write(0, 16'd4);
    idle(14);

    // Last write wins
    wait_cnt(0, 0, "wait_c0_0");
    write(0, 16'd7);
    write(0, 16'd5);
    idle(16);

    // Minimum legal divisor, then back to 10
    write(0, 16'd2);
    idle(8);
    write(0, 16'd10);
    idle(14);

    // Rejected writes must not disturb a pending value
    wait_cnt(1, 0, "wait_c1_0");
    write(1, 16'd4);
    write(1, 16'd1);
    write(0, 16'd0);
    idle(12);

    // Out-of-range select on the 3-channel instance
    write3(3, 16'd5);
    idle(1);
    write3(2, 16'd5);
    write3(0, 16'd1);
    idle(2);

    // Drop en[0] for 7 cycles mid-period
    wait_cnt(0, 4, "wait_c0_4");
    en = 2'b10;
    idle(7);
    en = 2'b11;
    idle(24);

    // en[1] falls on its wrap; program while idle, then resume
    wait_cnt(1, m_div[1] - 1, "wait_c1_wrap");
    en = 2'b01;
    idle(1);
    write(1, 16'd6);
    idle(3);
    en = 2'b11;
    idle(20);

    // Largest legal divisor accepted, then superseded by 3 before it lands
    wait_cnt(1, 0, "wait_c1_0b");
    write(1, 16'hFFFF);
    write(1, 16'd3);
    wait_applied("wait_apply_a");
    idle(6);

    // Asynchronous reset mid-period while ch0 is in its high phase
    wait_cnt(0, 6, "wait_c0_6");
    #3;
    reset_n = 1'b0;
    #1;
    check_zero("arst_a");
    @(negedge clk);
    check_zero("arst_b");
    reset_n = 1'b1;
    model_reset();
    idle(25);

`ifdef CLK_DIV_SYNC_EN
    // Phase-align N=4 and N=6: common tick every 12 cycles after sync
    write(0, 16'd4);
    write(1, 16'd6);
    wait_applied("wait_apply_b");
    idle(3);
    sync = 1'b1;
    step();
    sync = 1'b0;
    idle(30);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
